// File: rtl/dtc_vote_window.sv
// dtc_vote_window
// Majority-vote smoother for the 1-bit decision-tree classifiers. Keeps the
// last WINDOW decisions in a shift register together with a running count
// of ones. A two-threshold hysteresis turns that count into a stable class,
// and each result is presented on a single-entry valid/ready output register.
// Nothing is emitted until the window has been completely filled once.

module dtc_vote_window #(
    parameter int WINDOW    = 8,
    parameter int THRESH_HI = 5,
    parameter int THRESH_LO = 3,
    parameter int CW        = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_class,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_class,
    output logic [CW-1:0] out_count,
    output logic          out_full
);

    // FILL: window not yet populated. RUN: every accept evicts the oldest sample.
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Thresholds are cast once so that every comparison is done in CW bits.
    localparam logic [CW-1:0] WIN_C  = CW'(WINDOW);
    localparam logic [CW-1:0] HI_C   = CW'(THRESH_HI);
    localparam logic [CW-1:0] LO_C   = CW'(THRESH_LO);
    localparam logic [CW-1:0] LAST_C = CW'(WINDOW - 1);

    // State registers and their next-state values.
    logic [WINDOW-1:0] hist_q, hist_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic [0:0]        state_q, state_d;
    logic              class_q, class_d;
    logic              out_valid_q, out_valid_d;
    logic              out_class_q, out_class_d;
    logic [CW-1:0]     out_count_q, out_count_d;
    logic              out_full_q, out_full_d;

    // Datapath helpers.
    logic [WINDOW-1:0] hist_shift;
    logic [CW-1:0]     in_ext;
    logic [CW-1:0]     evict_ext;
    logic [CW-1:0]     new_count;
    logic              new_class;
    logic              accept;
    logic              last_fill;
    logic              evaluate;

    // History shifted by one place with the incoming decision at index 0.
    assign hist_shift[0] = in_class;
    generate
        for (genvar gi = 1; gi < WINDOW; gi++) begin : g_shift
            assign hist_shift[gi] = hist_q[gi-1];
        end
    endgenerate

    // A new sample is accepted whenever the output slot is free or being
    // drained this cycle; flush blocks the input for its whole duration.
    assign in_ready  = !flush && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    assign in_ext    = {{(CW-1){1'b0}}, in_class};
    assign evict_ext = {{(CW-1){1'b0}}, hist_q[WINDOW-1]};

    // While filling, the evicted position still holds its reset zero, but the
    // eviction term is only applied in RUN so the intent stays explicit.
    // Modulo CW arithmetic is fine: the final result is always 0..WINDOW.
    assign new_count = (state_q == ST_RUN) ? (count_q + in_ext - evict_ext)
                                           : (count_q + in_ext);

    // The accept that completes the window is the first one to produce output.
    assign last_fill = (state_q == ST_FILL) && (fill_q == LAST_C);
    assign evaluate  = accept && ((state_q == ST_RUN) || last_fill);

    // Hysteresis: set at or above HI, clear at or below LO, hold in between.
    always_comb begin
        new_class = class_q;
        if (new_count >= HI_C) begin
            new_class = 1'b1;
        end else if (new_count <= LO_C) begin
            new_class = 1'b0;
        end
    end

    // Next-state logic: flush wins over everything, then drain and load.
    always_comb begin
        hist_d      = hist_q;
        count_d     = count_q;
        fill_d      = fill_q;
        state_d     = state_q;
        class_d     = class_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_count_d = out_count_q;
        out_full_d  = out_full_q;

        if (flush) begin
            hist_d      = '0;
            count_d     = '0;
            fill_d      = '0;
            state_d     = ST_FILL;
            class_d     = 1'b0;
            out_valid_d = 1'b0;
            out_class_d = 1'b0;
            out_count_d = '0;
            out_full_d  = 1'b0;
        end else begin
            // Consumer takes the held result; a load below overrides this.
            if (out_ready) begin
                out_valid_d = 1'b0;
            end

            if (accept) begin
                hist_d  = hist_shift;
                count_d = new_count;

                if (state_q == ST_FILL) begin
                    fill_d = fill_q + 1'b1;
                    if (last_fill) begin
                        state_d    = ST_RUN;
                        out_full_d = 1'b1;
                    end
                end
            end

            if (evaluate) begin
                class_d     = new_class;
                out_class_d = new_class;
                out_count_d = new_count;
                out_valid_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            count_q     <= '0;
            fill_q      <= '0;
            state_q     <= ST_FILL;
            class_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= 1'b0;
            out_count_q <= '0;
            out_full_q  <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            count_q     <= count_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            class_q     <= class_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_count_q <= out_count_d;
            out_full_q  <= out_full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_count = out_count_q;
    assign out_full  = out_full_q;

`ifndef SYNTHESIS
    // The running count must never leave 0..WINDOW and must always equal the
    // number of ones actually held in the history.
    a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= WIN_C);
    a_count_pop : assert property (@(posedge clk) disable iff (!rst_n)
        count_q == CW'($countones(hist_q)));
    // The fill counter never runs past the window while filling.
    a_fill_range : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_FILL) |-> (fill_q < WIN_C));
    // A held result must not change while the consumer stalls.
    a_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready && !flush) |=>
            ($stable(out_count_q) && $stable(out_class_q) && out_valid_q));
`endif

endmodule

// File: doc/dtc_vote_window.md
Name: dtc_vote_window

Overview:
- Sequential post-processor placed directly downstream of the combinational decision-tree classifiers (dtc_* blocks, 1-bit class output).
- Takes one class decision per accepted input and keeps a sliding window of the last WINDOW decisions.
- Emits a smoothed, hysteresis-filtered class with the current vote count over a valid/ready handshake.
- Suppresses single-sample flicker before results reach the system-level consumer.

Parameters:
- WINDOW, 8: number of decisions in the sliding window; legal range 2..64.
- THRESH_HI, 5: vote count at or above which the smoothed class becomes 1; must satisfy THRESH_LO < THRESH_HI <= WINDOW.
- THRESH_LO, 3: vote count at or below which the smoothed class becomes 0; must be >= 0.
- CW, $clog2(WINDOW+1): derived count width; not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_class is valid this cycle.
- in_ready  output  1  block accepts in_class this cycle.
- in_class  input  1  raw decision from the upstream tree classifier.
- flush  input  1  synchronous clear of window and state; 1-cycle pulse or level.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_class  output  1  smoothed class.
- out_count  output  CW  number of 1s in the window after the accepted sample.
- out_full  output  1  window has held WINDOW samples since reset/flush; status, not qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - history shift register, fill counter, running count, hysteresis class reg, out_valid, out_class, out_count, out_full all 0.
  - FSM goes to FILL.
- Accept: accept = in_valid && in_ready && !flush.
- in_ready = !flush && (!out_valid || out_ready). This gives full throughput of one sample per cycle while the consumer keeps out_ready high.
- On accept, in_class shifts into hist[0]; hist[WINDOW-1] is evicted.
- Running count update:
  - In FILL: count += in_class.
  - In RUN: count = count + in_class - evicted bit.
  - Arithmetic in CW bits; never exceeds WINDOW and never underflows. Assertion required.
- FSM:
  - FILL: fill counter increments per accept. When the accept that brings fill to WINDOW occurs, go to RUN and set out_full = 1 on the next edge.
  - RUN: stays in RUN until flush or reset.
- Hysteresis, evaluated on new_count at each accept in RUN, and on the final accept of FILL:
  - new_count >= THRESH_HI: class_reg = 1.
  - new_count <= THRESH_LO: class_reg = 0.
  - otherwise class_reg is held.
  - class_reg is 0 after reset/flush.
- Output:
  - Each accept that is evaluated (the final FILL accept and every RUN accept) loads out_class = new class_reg and out_count = new_count, and sets out_valid on the next edge. Latency is 1 cycle from accept to out_valid.
  - Accepts in FILL before the window is full produce no output.
  - out_valid clears when out_ready is high and no new result loads the same cycle.
  - Simultaneous drain and load: the register holds the new result and out_valid stays 1.
  - Held outputs are stable while out_valid && !out_ready (no overwrite, since in_ready is low).
- Flush, synchronous, highest priority:
  - Clears history, count, fill, class_reg, out_full, out_valid; FSM goes to FILL.
  - A sample presented in the flush cycle is not accepted (in_ready low).
  - A pending undrained output is discarded.
- Reset mid-operation: immediate clear as above; no partial result is emitted after release.

Test Plan (WINDOW=8, THRESH_HI=5, THRESH_LO=3):
- Fill: after reset, 7 accepts of 1 -> out_valid stays 0, out_full 0. 8th accept of 1 -> next cycle out_valid=1, out_count=8, out_class=1, out_full=1.
- Hysteresis: full window of 1s, then feed 0s continuously with out_ready=1 -> out_count 7,6,5,4,3. out_class stays 1 through count 4 and drops to 0 at count 3. Then feed 1s: class returns to 1 only when count reaches 5.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_class/out_count unchanged for 5 cycles with in_valid=1. Release out_ready -> exactly one result per cycle resumes, no sample lost or duplicated (check count sequence).
- Eviction: window 10110010 (count 4), class currently 0; accept 1 while evicting 1 -> out_count=4, class stays 0 (hold band).
- Flush: flush in the same cycle as in_valid=1, with out_valid=1 pending -> next cycle out_valid=0, out_full=0, count=0. The following 8 accepts are required before any output.
- Async reset: assert rst_n low mid-cycle during RUN -> all outputs 0 immediately. After release, behaviour matches a fresh fill.
